// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 1-write register file with a pending-write scoreboard.
//
// After reset (or an init_req), an INIT sequence walks every entry and writes
// zero, one entry per cycle, so the storage array itself needs no reset. Entry 0
// always reads as zero and can never be marked pending.
//
// Optional feature (macro REGFILE_BYPASS_EN): write-to-read forwarding. When
// defined, a read port whose address matches a same-cycle write sees wdata and
// does not stall on that address. When undefined, reads return the stored
// value until the edge after the write.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width; DEPTH = 2**ADDR_W entries
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   init_req          re-run the clear sequence (from READY)
//   busy              clear sequence in progress
//   we, waddr, wdata  write port
//   ra1/rd1, ra2/rd2  combinational read ports
//   sb_set, sb_addr   mark an entry as having a pending write
//   stall             a read operand has a pending write

module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  output logic              stall
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    StInit,
    StReady
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DEPTH-1:0]  pending_q, pending_d;

  logic [DATA_W-1:0] regs [DEPTH];

  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              byp1, byp2;

  assign in_ready = (state_q == StReady);
  assign busy     = ~in_ready;

  // Next-state logic: FSM, clear index and scoreboard bits.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    unique case (state_q)
      StInit: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == {ADDR_W{1'b1}}) begin
          state_d = StReady;
        end
      end
      StReady: begin
        if (init_req) begin
          // Re-init wins over any same-cycle write or scoreboard update.
          state_d   = StInit;
          idx_d     = '0;
          pending_d = '0;
        end else begin
          if (we) begin
            pending_d[waddr] = 1'b0;
          end
          // Applied after the clear so a same-address set wins.
          if (sb_set) begin
            pending_d[sb_addr] = 1'b1;
          end
        end
      end
      default: begin
        state_d = StInit;
        idx_d   = '0;
      end
    endcase
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StInit;
      idx_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
    end
  end

  // Storage write port: INIT clears one entry per cycle, READY takes user writes.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = waddr;
    mem_data = wdata;
    if (!in_ready) begin
      mem_we   = 1'b1;
      mem_addr = idx_q;
      mem_data = '0;
    end else if (we && (waddr != '0) && !init_req) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array; rst gates the enable so a write racing reset is lost.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      regs[mem_addr] <= mem_data;
    end
  end

  // Forwarding match per read port.
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef REGFILE_BYPASS_EN
    byp1 = in_ready && we && (waddr != '0) && (ra1 == waddr);
    byp2 = in_ready && we && (waddr != '0) && (ra2 == waddr);
`endif
  end

  // Read ports: zero during INIT and for address 0.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (in_ready) begin
      if (byp1) begin
        rd1 = wdata;
      end else if (ra1 != '0) begin
        rd1 = regs[ra1];
      end
      if (byp2) begin
        rd2 = wdata;
      end else if (ra2 != '0) begin
        rd2 = regs[ra2];
      end
    end
  end

  assign stall = ~in_ready | (pending_q[ra1] & ~byp1) | (pending_q[ra2] & ~byp2);

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth DEPTH = 2**ADDR_W.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 init_req  input  1  request to re-run the clear sequence.
REQ-006 busy  output  1  clear sequence in progress.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  ADDR_W  write address.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 ra1, ra2  input  ADDR_W  read addresses, ports 1 and 2.
REQ-011 rd1, rd2  output  DATA_W  read data, ports 1 and 2.
REQ-012 sb_set  input  1  mark sb_addr as having a pending write.
REQ-013 sb_addr  input  ADDR_W  scoreboard address to mark.
REQ-014 stall  output  1  a read operand has a pending write.

Function
REQ-015 The FSM SHALL have two states: INIT and READY.
REQ-016 In INIT, the block SHALL write zero to entry idx each cycle, idx counting 0..DEPTH-1; after entry DEPTH-1 it SHALL go to READY on the next edge, so INIT lasts DEPTH cycles.
REQ-017 busy SHALL be 1 in INIT and 0 in READY.
REQ-018 In INIT, writes and sb_set SHALL be ignored, rd1/rd2 SHALL read 0, and stall SHALL be 1.
REQ-019 In READY, init_req=1 SHALL enter INIT with idx=0 and clear all pending bits on the next edge; it has priority over a simultaneous write.
REQ-020 In READY, we=1 with waddr!=0 SHALL store wdata at the edge; writes to address 0 SHALL be dropped.
REQ-021 Reads SHALL be combinational: rdN = regs[raN]; raN==0 SHALL always return 0.
REQ-022 The block SHALL keep one pending bit per entry; bit 0 SHALL be hardwired to 0.
REQ-023 sb_set=1 in READY SHALL set pending[sb_addr] at the edge.
REQ-024 we=1 in READY SHALL clear pending[waddr] at the edge.
REQ-025 On the same edge, if sb_set targets the same address as we, set SHALL win.
REQ-026 stall SHALL be combinational: (pending[ra1] or pending[ra2]), subject to REQ-018 and REQ-032.

Reset
REQ-027 rst=1 SHALL immediately force state INIT, idx=0, all pending bits 0, busy=1 and stall=1.
REQ-028 Storage SHALL NOT be asynchronously reset; it is cleared by the INIT sequence after rst deasserts.
REQ-029 If rst is asserted mid-INIT, the sequence SHALL restart from idx=0.
REQ-030 If rst is asserted mid-write, the write SHALL be discarded.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-032 With REGFILE_BYPASS_EN defined, in READY with we=1, waddr!=0 and raN==waddr, rdN SHALL equal wdata in the same cycle, and that port SHALL NOT contribute to stall.
REQ-033 Without REGFILE_BYPASS_EN, rdN SHALL return the old stored value until the edge after the write, and stall SHALL ignore the concurrent write.

Verification
REQ-034 Reset: rst pulse, ADDR_W=5 -> busy=1 for exactly 32 cycles after deassert, then busy=0; every entry reads 0.
REQ-035 Write/read: we=1, waddr=3, wdata=32'h19396328; next cycle ra1=3 -> rd1=32'h19396328; a write to address 0 -> ra2=0 reads 0.
REQ-036 Bypass: we=1, waddr=2, wdata=32'h23938222, ra1=2 in the same cycle -> rd1=32'h23938222 with the macro defined, old value (0) without it.
REQ-037 Scoreboard: sb_set at address 4, then ra2=4 -> stall=1; after a write to 4, stall=0 the next cycle; simultaneous sb_set and we to 5 -> pending[5] stays 1.
REQ-038 Mid-operation: init_req with entry 1 = 32'h11121951 -> busy=1 for 32 cycles, then ra1=1 reads 0 and all pending bits are 0; rst at INIT cycle 10 -> full 32-cycle restart.
